pipe_stage_latch: RTL and testbench

//  Parametrised pipeline stage register replacing the fixed per-stage latches
//  (fetch/dec, dec/reg, reg/exe, exe/wb). Carries a WIDTH-bit payload
//  (instruction plus control/data fields, packed by the caller) with a

---
 rtl/vi_pipe_pkg.sv | 25 ++
 rtl/pipe_stage_latch.sv | 123 ++++++++++++
 tb/tb_pipe_stage_latch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vi_pipe_pkg.sv
// Shared pipeline-boundary types.
//   pipe_state_t : occupancy state of one stage register (EMPTY/FULL/SKID)
//   PIPE_OCC_W   : width of the occupancy port
//   occ_of()     : maps a state to its entry count
package vi_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    localparam int PIPE_OCC_W = 2;

    function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_t s);
        logic [PIPE_OCC_W-1:0] r;
        case (s)
            ST_FULL: r = 2'd1;
            ST_SKID: r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_latch.sv
// Parametrised pipeline stage register with valid/ready handshake, stall
// and flush. One instance sits at each pipeline boundary.
//
// Parameters
//   WIDTH      payload width
//   SKID       1: two entries (main + skid), in_ready comes from a flop
//              0: single entry, in_ready = !out_valid | out_ready
//   RESET_DATA out_data value after reset or flush (e.g. NOP encoding)
// Ports
//   clock, reset        clock, synchronous active-high reset
//   flush               drop all held entries
//   in_valid/in_ready/in_data     upstream handshake + payload
//   out_valid/out_ready/out_data  downstream handshake + payload
//   occupancy           held entries (0..2)
module pipe_stage_latch
    import vi_pipe_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter int               SKID       = 1,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_val;   // skid payload (constant when SKID=0)
    logic             in_xfer, out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (reset || flush) begin
            // An in transfer this cycle is dropped; an out transfer has
            // already been taken by downstream and needs no action here.
            state_d = ST_EMPTY;
            main_d  = RESET_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        // Only reachable with a skid entry: SKID=0 never
                        // accepts while full and stalled.
                        if (SKID != 0) state_d = ST_SKID;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d = ST_FULL;
                        main_d  = skid_val;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = RESET_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    if (SKID != 0) begin : g_skid
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             in_ready_q, in_ready_d;

        // Skid payload needs no reset: it is only read in ST_SKID.
        always_comb begin
            skid_d = skid_q;
            if (in_xfer && !out_ready && state_q == ST_FULL) skid_d = in_data;
        end

        // Registered ready: the stall seen upstream is a flop output.
        assign in_ready_d = (state_d != ST_SKID);

        always_ff @(posedge clock) begin
            skid_q <= skid_d;
            if (reset) in_ready_q <= 1'b1;
            else       in_ready_q <= in_ready_d;
        end

        // Held low while reset is asserted so nothing is accepted that cycle.
        assign in_ready = in_ready_q & ~reset;
        assign skid_val = skid_q;
    end else begin : g_noskid
        assign in_ready = (~out_valid | out_ready) & ~reset;
        assign skid_val = RESET_DATA;
    end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: four instances
//   0: WIDTH=32 SKID=1   1: WIDTH=32 SKID=0
//   2: WIDTH=97 SKID=1   3: WIDTH=97 SKID=0
// Directed vectors run on instances 0/1, random traffic on all four.
module tb_pipe_stage_latch;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [3:0]        in_valid, in_ready, out_valid, out_ready;
    logic [3:0][96:0]  in_data;
    logic [3:0][96:0]  out_data;
    logic [3:0][1:0]   occ;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W  = (g < 2) ? 32 : 97;
        localparam int SK = (g % 2 == 0) ? 1 : 0;
        logic [W-1:0] od;
        pipe_stage_latch #(
            .WIDTH     (W),
            .SKID      (SK),
            .RESET_DATA(W'(32'h13))
        ) u_dut (
            .clock    (clk),
            .reset    (rst),
            .flush    (flush),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g][W-1:0]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (od),
            .occupancy(occ[g])
        );
        assign out_data[g] = 97'(od);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [96:0] act, input logic [96:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int          dut;
        logic        rs, fl, iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir, e_ov, e_cd;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int dut, input logic rs, input logic fl,
                                input logic iv, input logic [31:0] d, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic e_cd,
                                input logic [31:0] e_od, input logic [1:0] e_occ);
        vec_t v;
        v.dut = dut; v.rs = rs; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_cd = e_cd; v.e_od = e_od; v.e_occ = e_occ;
        return v;
    endfunction

    // Random-phase scoreboard: small ring per instance.
    logic [96:0] mdl [4][4];
    int          wp[4], rp[4], cnt[4], emitted[4];

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = '0; out_ready = '0; in_data = '0;

        // Fill vector table. Fields: dut rs fl iv d ordy | ir ov cd od occ
        // Test 1: streaming 0x1..0x8, out_ready=1, both SKID variants.
        for (int d = 0; d < 2; d++) begin
            vq.push_back(mk(d, 0, 0, 1, 32'h1, 1, 1, 0, 1, 32'h13, 0));
            for (int k = 1; k < 8; k++)
                vq.push_back(mk(d, 0, 0, 1, 32'(k + 1), 1, 1, 1, 1, 32'(k), 1));
            vq.push_back(mk(d, 0, 0, 0, 32'h0, 1, 1, 1, 1, 32'h8, 1));
            vq.push_back(mk(d, 0, 0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 0));
        end
        // Test 2: SKID=1 fills skid while stalled.
        vq.push_back(mk(0, 0, 0, 1, 32'hA,    0, 1, 0, 0, 32'h0, 0));
        vq.push_back(mk(0, 0, 0, 1, 32'hB,    0, 1, 1, 1, 32'hA, 1));
        vq.push_back(mk(0, 0, 0, 1, 32'hDEAD, 0, 0, 1, 1, 32'hA, 2));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,    1, 0, 1, 1, 32'hA, 2));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,    0, 1, 1, 1, 32'hB, 1));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,    1, 1, 1, 1, 32'hB, 1));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,    1, 1, 0, 0, 32'h0, 0));
        // Test 3: SKID=0 refuses 0xB until out_ready.
        vq.push_back(mk(1, 0, 0, 1, 32'hA, 0, 1, 0, 0, 32'h0, 0));
        vq.push_back(mk(1, 0, 0, 1, 32'hB, 0, 0, 1, 1, 32'hA, 1));
        vq.push_back(mk(1, 0, 0, 1, 32'hB, 1, 1, 1, 1, 32'hA, 1));
        vq.push_back(mk(1, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'hB, 1));
        vq.push_back(mk(1, 0, 0, 0, 32'h0, 1, 1, 1, 1, 32'hB, 1));
        vq.push_back(mk(1, 0, 0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 0));
        // Test 4: flush from occupancy 2, then flush with a live in transfer.
        vq.push_back(mk(0, 0, 0, 1, 32'hA, 0, 1, 0, 0, 32'h0,  0));
        vq.push_back(mk(0, 0, 0, 1, 32'hB, 0, 1, 1, 1, 32'hA,  1));
        vq.push_back(mk(0, 0, 1, 1, 32'hC, 0, 0, 1, 1, 32'hA,  2));
        vq.push_back(mk(0, 0, 0, 0, 32'h0, 1, 1, 0, 1, 32'h13, 0));
        for (int d = 0; d < 2; d++) begin
            vq.push_back(mk(d, 0, 0, 1, 32'hD, 0, 1, 0, 1, 32'h13, 0));
            vq.push_back(mk(d, 0, 1, 1, 32'hC, 1, 1, 1, 1, 32'hD,  1));
            vq.push_back(mk(d, 0, 0, 0, 32'h0, 1, 1, 0, 1, 32'h13, 0));
        end
        // Test 5: reset mid-stream with one entry held, then resume.
        vq.push_back(mk(0, 0, 0, 1, 32'hE,  0, 1, 0, 1, 32'h13, 0));
        vq.push_back(mk(0, 1, 0, 1, 32'hF,  0, 0, 1, 1, 32'hE,  1));
        vq.push_back(mk(0, 0, 0, 1, 32'h21, 1, 1, 0, 1, 32'h13, 0));
        vq.push_back(mk(0, 0, 0, 1, 32'h22, 1, 1, 1, 1, 32'h21, 1));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,  1, 1, 1, 1, 32'h22, 1));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,  1, 1, 0, 0, 32'h0,  0));

        // Reset state: in_ready low while reset is held, state cleared.
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst ir%0d", g),  97'(in_ready[g]),  97'(0));
            chk($sformatf("rst ov%0d", g),  97'(out_valid[g]), 97'(0));
            chk($sformatf("rst occ%0d", g), 97'(occ[g]),       97'(0));
            chk($sformatf("rst od%0d", g),  out_data[g],       97'h13);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < 4; g++)
            chk($sformatf("post-rst ir%0d", g), 97'(in_ready[g]), 97'(1));

        // Apply vectors: drive at negedge, sample 1 time unit later.
        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            @(negedge clk);
            rst       = v.rs;
            flush     = v.fl;
            in_valid  = '0;
            out_ready = '0;
            in_valid[v.dut]  = v.iv;
            out_ready[v.dut] = v.ordy;
            in_data[v.dut]   = 97'(v.d);
            #1;
            chk($sformatf("vec%0d ir", i),  97'(in_ready[v.dut]),  97'(v.e_ir));
            chk($sformatf("vec%0d ov", i),  97'(out_valid[v.dut]), 97'(v.e_ov));
            chk($sformatf("vec%0d occ", i), 97'(occ[v.dut]),       97'(v.e_occ));
            if (v.e_cd)
                chk($sformatf("vec%0d od", i), out_data[v.dut], 97'(v.e_od));
        end

        // Random traffic on all four instances with occasional flush.
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = '0; out_ready = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            wp[g] = 0; rp[g] = 0; cnt[g] = 0; emitted[g] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            flush = ($urandom_range(0, 99) == 0);
            for (int g = 0; g < 4; g++) begin
                logic [96:0] r;
                in_valid[g]  = ($urandom_range(0, 9) < 7);
                out_ready[g] = ($urandom_range(0, 9) < 6);
                r = 97'({$urandom(), $urandom(), $urandom(), $urandom()});
                if (g < 2) r = r & 97'hFFFF_FFFF;
                in_data[g] = r;
            end
            #1;
            for (int g = 0; g < 4; g++) begin
                logic exp_ir;
                exp_ir = (g % 2 == 0) ? (cnt[g] != 2) : (cnt[g] == 0 || out_ready[g]);
                chk($sformatf("rnd%0d occ", g), 97'(occ[g]),       97'(cnt[g]));
                chk($sformatf("rnd%0d ov", g),  97'(out_valid[g]), 97'(cnt[g] != 0));
                chk($sformatf("rnd%0d ir", g),  97'(in_ready[g]),  97'(exp_ir));
                if (out_valid[g] && out_ready[g]) begin
                    chk($sformatf("rnd%0d data", g), out_data[g], mdl[g][rp[g]]);
                    rp[g] = (rp[g] + 1) % 4;
                    cnt[g]--;
                    emitted[g]++;
                end
                if (flush) begin
                    cnt[g] = 0;
                    rp[g]  = wp[g];
                end else if (in_valid[g] && in_ready[g]) begin
                    mdl[g][wp[g]] = in_data[g];
                    wp[g] = (wp[g] + 1) % 4;
                    cnt[g]++;
                end
            end
        end
        @(negedge clk);
        flush = 1'b0; in_valid = '0;
        for (int g = 0; g < 4; g++)
            chk($sformatf("rnd%0d progress", g), 97'(emitted[g] > 1000), 97'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
